// File: rtl/count_display_driver_pkg.sv
// Shared definitions for the count display driver: FSM state encodings
// and active-high seven-segment patterns (bit0=a .. bit6=g).
package count_display_driver_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

endpackage

// File: rtl/count_display_driver_if.sv
// Value/handshake/display bundle between the counter side (master) and
// the display driver (slave).
interface count_display_driver_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    val;
  logic                start;
  logic                auto_en;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] seg;

  modport master (
    output val, start, auto_en,
    input  busy, done, bcd, seg
  );

  modport slave (
    input  val, start, auto_en,
    output busy, done, bcd, seg
  );
endinterface

// File: rtl/count_display_driver_seg7_decode.sv
// Combinational BCD digit to seven-segment decode with a blank override.
import count_display_driver_pkg::*;

module seg7_decode (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // NOTE: always_comb assigns a default on every path so no latch is inferred.
  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// Sequential double-dabble binary-to-BCD converter (one bit per clock)
// driving a multi-digit seven-segment display with leading-zero blanking.
import count_display_driver_pkg::*;

module count_display_driver #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int BLANK  = 1
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  count_display_driver_if.slave io
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e              state_q;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d, adj_d;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    last_q;
  logic                busy_q, done_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                go;
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg;

  assign go = io.start | (io.auto_en & (io.val != last_q));

  // Add-3 correction on every nibble, then one left shift of {scratch, shift}.
  always_comb begin
    adj_d = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) adj_d[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
    {scratch_d, shift_d} = {adj_d[4*DIGITS-2:0], shift_q, 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            shift_q   <= io.val;
            last_q    <= io.val;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_q   <= shift_d;
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= scratch_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Digit i>0 blanks only when it and every digit above it are zero.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_upper
      assign blank[i] = (BLANK != 0) && (bcd_q[4*DIGITS-1:4*i] == '0);
    end
    seg7_decode u_dec (
      .digit_i (bcd_q[4*i +: 4]),
      .blank_i (blank[i]),
      .seg_o   (seg[7*i +: 7])
    );
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.bcd  = bcd_q;
  assign io.seg  = seg;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed self-checking bench for count_display_driver (WIDTH=8, DIGITS=3, BLANK=1).
module tb_count_display_driver;

  logic clk = 1'b0;
  logic res;
  int   n_checks = 0;
  int   n_errors = 0;

  count_display_driver_if #(.WIDTH(8), .DIGITS(3)) bus ();

  count_display_driver #(.WIDTH(8), .DIGITS(3), .BLANK(1)) dut (
    .clk_i (clk),
    .res_i (res),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step n cycles (sampling on falling edges) and count DONE pulses seen.
  task automatic step(input int n, output int dones);
    dones = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
  endtask

  // Pulse START with value v, then expect DONE exactly after 8 edges.
  task automatic convert(input string tag, input logic [7:0] v,
                         input logic [11:0] exp_bcd, input logic [20:0] exp_seg);
    int cyc;
    int busy_cycles;
    int extra;
    @(negedge clk);
    bus.val   = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    cyc         = 0;
    busy_cycles = bus.busy ? 1 : 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cycles++;
    end
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_busy_cycles"}, busy_cycles, 8);
    check({tag, "_bcd"}, bus.bcd, exp_bcd);
    check({tag, "_seg"}, bus.seg, exp_seg);
    step(3, extra);
    check({tag, "_single_done"}, extra, 0);
  endtask

  initial begin
    int d;
    bus.val     = '0;
    bus.start   = 1'b0;
    bus.auto_en = 1'b0;
    res         = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;

    check("rst_bcd",  bus.bcd,  12'h000);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_seg",  bus.seg,  {7'h00, 7'h00, 7'h3F});

    convert("v255", 8'd255, 12'h255, {7'h5B, 7'h6D, 7'h6D});
    convert("v100", 8'd100, 12'h100, {7'h06, 7'h3F, 7'h3F});
    convert("v9",   8'd9,   12'h009, {7'h00, 7'h00, 7'h6F});
    convert("v10",  8'd10,  12'h010, {7'h00, 7'h06, 7'h3F});

    // START while busy is ignored; VAL changed mid-conversion is not captured.
    @(negedge clk);
    bus.val   = 8'd37;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    step(2, d);
    bus.start = 1'b1;
    bus.val   = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    step(10, d);
    check("busy_ignore_dones", d, 1);
    check("busy_ignore_bcd", bus.bcd, 12'h037);

    // AUTO mode following a counter stepping 0 -> 1 -> 2.
    bus.auto_en = 1'b1;
    bus.val     = 8'd0;
    step(20, d);
    check("auto0_dones", d, 1);
    check("auto0_bcd", bus.bcd, 12'h000);
    bus.val = 8'd1;
    step(20, d);
    check("auto1_dones", d, 1);
    check("auto1_bcd", bus.bcd, 12'h001);
    check("auto1_seg", bus.seg, {7'h00, 7'h00, 7'h06});
    bus.val = 8'd2;
    step(20, d);
    check("auto2_dones", d, 1);
    check("auto2_bcd", bus.bcd, 12'h002);
    step(20, d);
    check("auto_stable_dones", d, 0);

    // START together with the AUTO condition: one conversion only.
    bus.val   = 8'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    step(20, d);
    check("start_auto_dones", d, 1);
    check("start_auto_bcd", bus.bcd, 12'h003);
    bus.auto_en = 1'b0;

    // START held high: back-to-back conversions every 9 cycles.
    bus.val   = 8'd5;
    bus.start = 1'b1;
    step(18, d);
    bus.start = 1'b0;
    check("held_start_dones", d, 2);
    check("held_start_bcd", bus.bcd, 12'h005);
    step(12, d);
    check("held_start_after", d, 0);

    // Reset mid-conversion (with START asserted on the same edge).
    @(negedge clk);
    bus.val   = 8'd128;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    step(3, d);
    check("abort_pre_dones", d, 0);
    res       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    res       = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_bcd", bus.bcd, 12'h000);
    step(12, d);
    check("abort_no_done", d, 0);
    check("abort_seg", bus.seg, {7'h00, 7'h00, 7'h3F});

    convert("v128", 8'd128, 12'h128, {7'h06, 7'h5B, 7'h7F});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
